sm_intc: RTL and testbench

SM_INTC -- requirements
Module: sm_intc

---
 rtl/sm_intc.sv | 114 +++++++++++
 tb/tb_sm_intc.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_intc.sv
// rtl/sm_intc.sv - fixed-priority nesting interrupt controller with claim/complete
// Sources pass a 2-flop synchronizer; edge sources latch, level sources follow the line.
module sm_intc #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [2:0]       bus_a,
  input  logic             bus_we,
  input  logic             bus_re,
  input  logic [31:0]      bus_wd,
  output logic [31:0]      bus_rd,
  output logic             irq_o
);

  localparam int PAD = 32 - N_IRQ;

  logic [N_IRQ-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [N_IRQ-1:0] edge_lat_q, edge_lat_d;
  logic [N_IRQ-1:0] enable_q, enable_d;
  logic [N_IRQ-1:0] edge_cfg_q, edge_cfg_d;
  logic [N_IRQ-1:0] insvc_q, insvc_d;

  logic [N_IRQ-1:0] pending, req, rise;
  logic [N_IRQ-1:0] claim_mask, cmpl_mask;
  logic             best_vld, top_vld;
  logic [2:0]       best_id, top_id;
  logic             claim_fire, cmpl_fire;
  logic             unused_wd;

  assign unused_wd = ^bus_wd[31:N_IRQ];

  assign pending = (s2_q & ~edge_cfg_q) | (edge_lat_q & edge_cfg_q);
  assign req     = pending & enable_q;
  assign rise    = s2_q & ~s3_q;

  // Descending scan so the last hit is the lowest (highest-priority) ID.
  always_comb begin
    best_vld = 1'b0;
    best_id  = 3'd0;
    top_vld  = 1'b0;
    top_id   = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        best_vld = 1'b1;
        best_id  = 3'(i);
      end
      if (insvc_q[i]) begin
        top_vld = 1'b1;
        top_id  = 3'(i);
      end
    end
  end

  assign irq_o      = best_vld && (!top_vld || (best_id < top_id));
  assign claim_fire = bus_re && (bus_a == 3'd3) && irq_o;
  assign cmpl_fire  = bus_we && (bus_a == 3'd3);

  always_comb begin
    claim_mask = '0;
    cmpl_mask  = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      claim_mask[i] = claim_fire && (best_id == 3'(i));
      cmpl_mask[i]  = cmpl_fire && (bus_wd[2:0] == 3'(i));
    end
  end

  always_comb begin
    s1_d       = irq_i;
    s2_d       = s1_q;
    s3_d       = s2_q;
    enable_d   = enable_q;
    edge_cfg_d = edge_cfg_q;
    if (bus_we && (bus_a == 3'd1)) enable_d = bus_wd[N_IRQ-1:0];
    if (bus_we && (bus_a == 3'd2)) edge_cfg_d = bus_wd[N_IRQ-1:0];
    // A fresh edge outranks a claim clear so a back-to-back event is kept.
    edge_lat_d = ((edge_lat_q & ~(claim_mask & edge_cfg_q)) | rise) & edge_cfg_d;
    insvc_d    = (insvc_q & ~cmpl_mask) | claim_mask;
  end

  always_comb begin
    bus_rd = 32'h0;
    case (bus_a)
      3'd0:    bus_rd = {{PAD{1'b0}}, pending};
      3'd1:    bus_rd = {{PAD{1'b0}}, enable_q};
      3'd2:    bus_rd = {{PAD{1'b0}}, edge_cfg_q};
      3'd3:    bus_rd = irq_o ? {1'b1, 28'h0, best_id} : 32'h0;
      3'd4:    bus_rd = {{PAD{1'b0}}, insvc_q};
      default: bus_rd = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      edge_lat_q <= '0;
      enable_q   <= '0;
      edge_cfg_q <= '0;
      insvc_q    <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      edge_lat_q <= edge_lat_d;
      enable_q   <= enable_d;
      edge_cfg_q <= edge_cfg_d;
      insvc_q    <= insvc_d;
    end
  end

endmodule

// File: tb/tb_sm_intc.sv
// tb/tb_sm_intc.sv - directed vector table, reset sequence and randomized model check for sm_intc
module tb_sm_intc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_i;
  logic [2:0]  bus_a;
  logic        bus_we, bus_re;
  logic [31:0] bus_wd;
  logic [31:0] bus_rd;
  logic        irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  sm_intc #(.N_IRQ(8)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .bus_a(bus_a), .bus_we(bus_we),
    .bus_re(bus_re), .bus_wd(bus_wd), .bus_rd(bus_rd), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a;
    logic        we;
    logic        re;
    logic [31:0] wd;
    logic [7:0]  irq;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [2:0] a, logic we, logic re, logic [31:0] wd,
                              logic [7:0] irq, logic [31:0] exp_rd, logic exp_irq);
    vec_t v;
    v.a = a; v.we = we; v.re = re; v.wd = wd; v.irq = irq;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic [2:0] a, logic we, logic re, logic [31:0] wd, logic [7:0] irq);
    bus_a = a; bus_we = we; bus_re = re; bus_wd = wd; irq_i = irq;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: registers as plain bytes, synchronizer as a history of sampled inputs.
  logic [7:0] m_en, m_ecfg, m_lat, m_ins;
  logic [7:0] m_hist[$];

  function automatic logic [7:0] seen(int age);
    if (m_hist.size() < age) return 8'h0;
    return m_hist[m_hist.size() - age];
  endfunction

  function automatic int lowest(logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_pend();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_ecfg[i] ? m_lat[i] : seen(2) >> i;
    return p;
  endfunction

  function automatic logic m_irq();
    int b, t;
    b = lowest(m_pend() & m_en);
    t = lowest(m_ins);
    return (b >= 0) && (t < 0 || b < t);
  endfunction

  function automatic logic [31:0] m_rd(logic [2:0] a);
    case (a)
      3'd0: return {24'h0, m_pend()};
      3'd1: return {24'h0, m_en};
      3'd2: return {24'h0, m_ecfg};
      3'd3: return m_irq() ? (32'h8000_0000 | 32'(lowest(m_pend() & m_en))) : 32'h0;
      3'd4: return {24'h0, m_ins};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_reset();
    m_en = 0; m_ecfg = 0; m_lat = 0; m_ins = 0;
    m_hist.delete();
  endfunction

  function automatic void m_edge(logic [2:0] a, logic we, logic re, logic [31:0] wd, logic [7:0] irq);
    logic       claim;
    int         b;
    logic [7:0] bmask, new_ins, new_en, new_ecfg, rising;
    claim    = re && a == 3 && m_irq();
    b        = lowest(m_pend() & m_en);
    bmask    = claim ? (8'h1 << b) : 8'h0;
    new_ins  = m_ins;
    if (we && a == 3) new_ins = new_ins & ~(8'h1 << wd[2:0]);
    new_ins  = new_ins | bmask;
    new_en   = (we && a == 1) ? wd[7:0] : m_en;
    new_ecfg = (we && a == 2) ? wd[7:0] : m_ecfg;
    rising   = seen(2) & ~seen(3);
    m_lat    = ((m_lat & ~(bmask & m_ecfg)) | rising) & new_ecfg;
    m_ins    = new_ins;
    m_en     = new_en;
    m_ecfg   = new_ecfg;
    m_hist.push_back(irq);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
  endfunction

  initial begin
    // a, we, re, wd, irq, expected rd, expected irq_o
    add(1,1,0,32'h1,8'h00,32'h0,0);        add(2,1,0,32'h0,8'h00,32'h0,0);
    add(1,0,0,32'h0,8'h01,32'h1,0);        add(0,0,0,32'h0,8'h01,32'h0,0);
    add(3,0,0,32'h0,8'h01,32'h80000000,1); add(3,0,1,32'h0,8'h01,32'h80000000,1);
    add(4,0,0,32'h0,8'h01,32'h1,0);        add(3,0,0,32'h0,8'h00,32'h0,0);
    add(3,1,0,32'h0,8'h00,32'h0,0);        add(4,0,0,32'h0,8'h00,32'h0,0);
    add(1,1,0,32'hFF,8'h00,32'h1,0);       add(2,1,0,32'h20,8'h00,32'h0,0);
    add(0,0,0,32'h0,8'h20,32'h0,0);        add(0,0,0,32'h0,8'h00,32'h0,0);
    add(0,0,0,32'h0,8'h00,32'h0,0);        add(0,0,0,32'h0,8'h00,32'h20,1);
    add(3,0,1,32'h0,8'h00,32'h80000005,1); add(0,0,0,32'h0,8'h00,32'h0,0);
    add(4,0,0,32'h0,8'h00,32'h20,0);       add(3,1,0,32'h5,8'h00,32'h0,0);
    add(4,0,0,32'h0,8'h00,32'h0,0);        add(2,1,0,32'h0,8'h00,32'h20,0);
    add(0,0,0,32'h0,8'h10,32'h0,0);        add(0,0,0,32'h0,8'h10,32'h0,0);
    add(3,0,1,32'h0,8'h10,32'h80000004,1); add(4,0,0,32'h0,8'h50,32'h10,0);
    add(0,0,0,32'h0,8'h50,32'h10,0);       add(0,0,0,32'h0,8'h50,32'h50,0);
    add(0,0,0,32'h0,8'h52,32'h50,0);       add(3,0,0,32'h0,8'h52,32'h0,0);
    add(3,0,0,32'h0,8'h52,32'h80000001,1); add(3,0,1,32'h0,8'h52,32'h80000001,1);
    add(4,0,0,32'h0,8'h52,32'h12,0);       add(3,1,0,32'h1,8'h00,32'h0,0);
    add(3,1,0,32'h4,8'h00,32'h80000001,1); add(4,0,0,32'h0,8'h00,32'h0,0);
    add(2,1,0,32'h8,8'h00,32'h0,0);        add(0,0,0,32'h0,8'h08,32'h0,0);
    add(0,0,0,32'h0,8'h00,32'h0,0);        add(0,0,0,32'h0,8'h08,32'h0,0);
    add(0,0,0,32'h0,8'h00,32'h8,1);        add(3,0,1,32'h0,8'h00,32'h80000003,1);
    add(0,0,0,32'h0,8'h00,32'h8,0);        add(4,0,0,32'h0,8'h00,32'h8,0);
    add(3,1,0,32'h3,8'h00,32'h0,0);        add(3,0,0,32'h0,8'h00,32'h80000003,1);
    add(3,0,1,32'h0,8'h00,32'h80000003,1); add(0,0,0,32'h0,8'h00,32'h0,0);
    add(3,1,0,32'h3,8'h00,32'h0,0);        add(2,1,0,32'h4,8'h00,32'h8,0);
    add(0,0,0,32'h0,8'h04,32'h0,0);        add(0,0,0,32'h0,8'h00,32'h0,0);
    add(0,0,0,32'h0,8'h00,32'h0,0);        add(3,0,1,32'h0,8'h00,32'h80000002,1);
    add(3,1,0,32'h7,8'h00,32'h0,0);        add(4,0,0,32'h0,8'h00,32'h4,0);
    add(3,0,1,32'h0,8'h00,32'h0,0);        add(4,0,0,32'h0,8'h00,32'h4,0);
    add(0,0,0,32'h0,8'h00,32'h0,0);        add(3,1,0,32'h2,8'h00,32'h0,0);
    add(1,1,0,32'h0,8'h00,32'hFF,0);       add(0,0,0,32'h0,8'h04,32'h0,0);
    add(0,0,0,32'h0,8'h00,32'h0,0);        add(0,0,0,32'h0,8'h00,32'h0,0);
    add(0,0,0,32'h0,8'h00,32'h4,0);        add(1,1,0,32'h4,8'h00,32'h0,0);
    add(3,0,0,32'h0,8'h00,32'h80000002,1); add(5,1,0,32'hFFFFFFFF,8'h00,32'h0,1);
    add(6,0,0,32'h0,8'h00,32'h0,1);        add(3,0,1,32'h0,8'h00,32'h80000002,1);
    add(3,1,0,32'h2,8'h00,32'h0,0);        add(2,1,0,32'h0,8'h00,32'h4,0);

    // Reset state with every line high.
    rst_n = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 32'h0, 8'hFF);
    step(); step();
    check("reset_irq_o", 32'(irq_o), 32'h0);
    for (int a = 0; a < 8; a++) begin
      bus_a = 3'(a);
      #1;
      check($sformatf("reset_rd_a%0d", a), bus_rd, 32'h0);
    end
    irq_i = 8'h0;
    rst_n = 1'b1;
    step(); step();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].a, tbl[i].we, tbl[i].re, tbl[i].wd, tbl[i].irq);
      @(negedge clk);
      check($sformatf("vec%0d_rd", i), bus_rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_irq", i), 32'(irq_o), 32'(tbl[i].exp_irq));
      step();
    end

    // Build INSERVICE = 0x03 by nesting ID 0 over ID 1, then reset mid-service.
    drive(3'd1, 1'b1, 1'b0, 32'hFF, 8'h00); step();
    drive(3'd0, 1'b0, 1'b0, 32'h0, 8'h02); step(); step(); step();
    bus_a = 3'd3; bus_re = 1'b1;
    @(negedge clk); check("nest_claim1", bus_rd, 32'h80000001);
    step(); bus_re = 1'b0;
    irq_i = 8'h03; step(); step(); step();
    bus_re = 1'b1;
    @(negedge clk); check("nest_claim0", bus_rd, 32'h80000000);
    step(); bus_re = 1'b0; bus_a = 3'd4;
    @(negedge clk); check("nest_insvc", bus_rd, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_irq_o", 32'(irq_o), 32'h0);
    for (int a = 0; a < 8; a++) begin
      bus_a = 3'(a);
      #1;
      check($sformatf("midreset_rd_a%0d", a), bus_rd, 32'h0);
    end
    step();
    rst_n = 1'b1;
    bus_a = 3'd0;
    @(negedge clk); check("rel_pend_e0", bus_rd, 32'h0);
    step();
    @(negedge clk); check("rel_pend_e1", bus_rd, 32'h0);
    step();
    @(negedge clk); check("rel_pend_e2", bus_rd, 32'h3);
    check("rel_irq_disabled", 32'(irq_o), 32'h0);
    step(); step();
    drive(3'd2, 1'b1, 1'b0, 32'h3, 8'h03); step();
    drive(3'd0, 1'b0, 1'b0, 32'h0, 8'h03);
    @(negedge clk); check("rel_no_edge_latch", bus_rd, 32'h0);
    bus_a = 3'd2;
    @(negedge clk); check("rel_edge_cfg", bus_rd, 32'h3);

    // Randomized traffic against the model.
    rst_n = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 32'h0, 8'h00);
    m_reset();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [2:0]  a;
      logic        we, re;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 2) == 0);
      wd = (a == 3) ? 32'($urandom_range(0, 7)) : $urandom;
      irq_i = irq_i ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      drive(a, we, re, wd, irq_i);
      @(negedge clk);
      check($sformatf("rnd%0d_rd_a%0d", c, a), bus_rd, m_rd(a));
      check($sformatf("rnd%0d_irq", c), 32'(irq_o), 32'(m_irq()));
      @(posedge clk);
      m_edge(a, we, re, wd, irq_i);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
